// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared state encoding and address-field geometry for the data cache.
package data_cache_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE_THROUGH} state_t;
  localparam int DEF_INDEX_BITS = 4;
  localparam int DEF_WORD_SELECT_BITS = 2;
  function automatic int tag_bits(input int ib, input int wb);
    return 30 - ib - wb;
  endfunction
  function automatic int index_lsb(input int wb);
    return wb + 2;
  endfunction
  localparam int TAG_BITS = tag_bits(DEF_INDEX_BITS, DEF_WORD_SELECT_BITS);
  localparam int BLOCK_WORDS = 1 << DEF_WORD_SELECT_BITS;
endpackage

// File: rtl/data_cache_line_array.sv
// data_cache_line_array: tag/valid/data storage with a combinational read port and synchronous word/fill ports.
module data_cache_line_array #(
  parameter int INDEX_BITS = 4,
  parameter int WORD_SELECT_BITS = 2,
  parameter int TAG_BITS = 24
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [INDEX_BITS-1:0]       index,
  input  logic [WORD_SELECT_BITS-1:0] rd_word,
  output logic                        rd_valid,
  output logic [TAG_BITS-1:0]         rd_tag,
  output logic [31:0]                 rd_data,
  input  logic                        wr_en,
  input  logic [WORD_SELECT_BITS-1:0] wr_word,
  input  logic [31:0]                 wr_data,
  input  logic                        fill_en,
  input  logic [TAG_BITS-1:0]         fill_tag
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << WORD_SELECT_BITS;
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES][WORDS];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) valid <= '0;
    else if (fill_en) valid[index] <= 1'b1;
  always_ff @(posedge clock) begin
    if (wr_en) data[index][wr_word] <= wr_data;
    if (fill_en) tags[index] <= fill_tag;
  end
  assign rd_valid = valid[index];
  assign rd_tag = tags[index];
  assign rd_data = data[index][rd_word];
endmodule

// File: rtl/data_cache_controller.sv
// data_cache_controller: direct-mapped write-through no-write-allocate data cache for the MEM stage.
module data_cache_controller
  import data_cache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int WORD_SELECT_BITS = DEF_WORD_SELECT_BITS
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] data_memory_read_data,
  output logic        hit,
  output logic        mem_read_request,
  output logic        mem_write_request,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready
);
  localparam int LTAG = tag_bits(INDEX_BITS, WORD_SELECT_BITS);
  localparam int ILSB = index_lsb(WORD_SELECT_BITS);
  state_t state;
  logic [WORD_SELECT_BITS-1:0] count, wsel;
  logic [INDEX_BITS-1:0] idx;
  logic [LTAG-1:0] tag, rd_tag;
  logic [31:0] rd_data;
  logic rd_valid, lookup_hit, refill_step, wt_done, load_hit;
  logic unused_byte_bits;
  assign unused_byte_bits = ^address[1:0];
  assign wsel = address[ILSB-1:2];
  assign idx = address[ILSB +: INDEX_BITS];
  assign tag = address[31 -: LTAG];
  assign lookup_hit = rd_valid && rd_tag == tag;
  assign refill_step = state == REFILL && mem_ready;
  assign wt_done = state == WRITE_THROUGH && mem_ready;
  assign load_hit = state == IDLE && MemRead && !MemWrite && lookup_hit;
  assign hit = state == REFILL ? 1'b0 : state == WRITE_THROUGH ? mem_ready : MemWrite ? 1'b0 : !MemRead || lookup_hit;
  assign data_memory_read_data = load_hit ? rd_data : '0;
  assign mem_read_request = state == REFILL;
  assign mem_write_request = state == WRITE_THROUGH;
  assign mem_address = state == REFILL ? {tag, idx, count, 2'b00} : state == WRITE_THROUGH ? {address[31:2], 2'b00} : '0;
  assign mem_write_data = state == WRITE_THROUGH ? write_data : '0;
  // Stores only touch the array when the line already holds that block.
  data_cache_line_array #(
    .INDEX_BITS(INDEX_BITS),
    .WORD_SELECT_BITS(WORD_SELECT_BITS),
    .TAG_BITS(LTAG)
  ) lines (
    .clock(clock),
    .reset_n(reset_n),
    .index(idx),
    .rd_word(wsel),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(rd_data),
    .wr_en(refill_step || (wt_done && lookup_hit)),
    .wr_word(state == REFILL ? count : wsel),
    .wr_data(state == REFILL ? mem_read_data : write_data),
    .fill_en(refill_step && &count),
    .fill_tag(tag)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE:
          if (MemWrite) state <= WRITE_THROUGH;
          else if (MemRead && !lookup_hit) begin
            state <= REFILL;
            count <= '0;
          end
        REFILL:
          if (mem_ready) begin
            count <= count + 1'b1;
            if (&count) state <= IDLE;
          end
        WRITE_THROUGH:
          if (mem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/data_cache_controller.md
Name: data_cache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate data cache that answers the MEM-stage load/store requests whose results enter MEM_WB_pipeline_register.
- Produces data_memory_read_data and the hit/ready signal that gates the pipeline registers.
- hit=0 stalls the pipeline; the MEM stage holds its request stable until hit=1.
- On a miss, refills a multi-word block from main memory through a request/ready handshake; stores go through to memory.

Parameters:
INDEX_BITS, 4, number of line-index bits (2**INDEX_BITS lines)
WORD_SELECT_BITS, 2, word-select bits per block (2**WORD_SELECT_BITS words per line)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
MemRead  input  1  load request from MEM stage
MemWrite  input  1  store request from MEM stage
address  input  32  byte address; bits [1:0] ignored
write_data  input  32  store data
data_memory_read_data  output  32  load result
hit  output  1  1 = request complete or no request, pipeline may advance; 0 = stall
mem_read_request  output  1  main-memory word read request
mem_write_request  output  1  main-memory word write request
mem_address  output  32  word-aligned main-memory address
mem_write_data  output  32  store data to main memory
mem_read_data  input  32  word returned by main memory
mem_ready  input  1  one-cycle pulse: current memory word transfer complete

Behaviour:
- Address split:
  - word select = address[WORD_SELECT_BITS+1:2]
  - index = next INDEX_BITS bits
  - tag = remaining upper bits
- State register, reset value IDLE. States: IDLE, REFILL, WRITE_THROUGH.
- Reset (async, any state, including mid-refill or mid-write):
  - all valid bits 0; state IDLE; refill counter 0
  - mem_read_request, mem_write_request, mem_address, mem_write_data = 0
  - data_memory_read_data = 0
  - an aborted refill leaves its line invalid
- IDLE, combinational outputs:
  - No request: hit=1.
  - MemRead and the line is valid and tag matches: hit=1; data_memory_read_data = selected word in the same cycle (zero-latency hit).
  - MemRead miss: hit=0; next state REFILL; refill counter 0.
  - MemWrite: hit=0; next state WRITE_THROUGH.
  - MemRead and MemWrite together: MemWrite takes priority.
- REFILL:
  - Outputs: mem_read_request=1; mem_address = {tag, index, counter, 2'b00}.
  - Each mem_ready: store mem_read_data into word[counter]; counter increments.
  - On mem_ready with counter = last word: write tag, set valid, return to IDLE.
  - The held load then hits on the following cycle, so miss latency = block transfer + 1 cycle.
  - hit=0 throughout REFILL.
  - Counter wraps to 0 after the last word.
- WRITE_THROUGH:
  - Outputs: mem_write_request=1; mem_address = word-aligned address; mem_write_data = write_data.
  - On mem_ready: hit=1 in that same cycle; return to IDLE.
  - If the line is valid and tag matches, update the cached word at that edge. A miss does not allocate.
  - The store is issued exactly once: the pipeline advances on the mem_ready edge.
- mem_ready outside REFILL/WRITE_THROUGH is ignored.
- data_memory_read_data is 0 when no load hit is being reported.
- Request signals stay asserted until mem_ready, even if the MEM inputs change (they are required stable while hit=0).

Decomposition:
- Package data_cache_pkg:
  - state enum (IDLE, REFILL, WRITE_THROUGH)
  - TAG_BITS derived constant
  - address-field slice helpers/constants
  - BLOCK_WORDS constant
- Sub-module data_cache_line_array:
  - tag/valid/data storage
  - one combinational read port; one synchronous word write port
  - synchronous line-fill (tag+valid) port
  - async clear of valid bits on reset_n

Test Plan:
- Reset, then MemRead address 0x40 -> hit=0; mem_address steps 0x40, 0x44, 0x48, 0x4C on each mem_ready (data 111, 112, 113, 114); hit=1 with data_memory_read_data=111 one cycle after the 4th mem_ready.
- After the refill above, MemRead 0x48 -> hit=1, data_memory_read_data=113 the same cycle; no mem_read_request.
- MemWrite 0x44, write_data=222 -> mem_write_request=1, mem_address=0x44, mem_write_data=222; hit=1 on the mem_ready cycle; a following read of 0x44 hits with 222.
- MemWrite to uncached 0x800, then MemRead 0x800 -> write goes through without allocation; the read misses and refills.
- Conflict: read 0x40 (cached), then read 0x440 (same index, different tag) -> refill evicts; re-read of 0x40 misses again.
- reset_n low after the 2nd refill mem_ready -> requests drop immediately, hit=1 when idle; a subsequent read of 0x40 misses and refills all 4 words.
